// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - fetch/decode/execute sequencer with fetch timeout fault
// One instruction per FETCH-DECODE-EXEC pass; a stalled fetch parks the core in FAULT until reset.
module fetch_seq #(
  parameter int PC_W     = 11,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            imem_ack,
  input  logic [8:0]      instr,
  input  logic [7:0]      do_a,
  input  logic [7:0]      lut_tgt,
  output logic [PC_W-1:0] PC,
  output logic            imem_req,
  output logic [8:0]      ir,
  output logic            exec_en,
  output logic            done,
  output logic            err
);

  localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(MAX_WAIT - 1);
  localparam logic [8:0]       HALT_INSTR = 9'h1FF;
  localparam logic [2:0]       OP_BZ      = 3'b100;
  localparam logic [2:0]       OP_BNZ     = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       op;
  logic             taken;

  assign op    = ir[8:6];
  assign taken = ((op == OP_BZ) && (do_a == 8'd0)) || ((op == OP_BNZ) && (do_a != 8'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      PC       <= '0;
      ir       <= '0;
      wait_cnt <= '0;
      imem_req <= 1'b0;
      exec_en  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      exec_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            PC       <= '0;
            wait_cnt <= '0;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          // An ack in the last allowed cycle still beats the timeout.
          if (imem_ack) begin
            ir       <= instr;
            wait_cnt <= '0;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else if (wait_cnt == LAST_WAIT) begin
            imem_req <= 1'b0;
            err      <= 1'b1;
            state    <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          if (ir == HALT_INSTR) begin
            done  <= 1'b1;
            state <= S_HALT;
          end else begin
            exec_en <= 1'b1;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          PC       <= taken ? PC_W'(lut_tgt) : PC + PC_W'(1);
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            done     <= 1'b0;
            PC       <= '0;
            wait_cnt <= '0;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - randomized self-checking bench for fetch_seq
// Expected PCs come from an instruction-level model of the branch/increment rule.
module tb_fetch_seq;

  localparam int PC_W     = 11;
  localparam int MAX_WAIT = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            imem_ack;
  logic [8:0]      instr;
  logic [7:0]      do_a;
  logic [7:0]      lut_tgt;
  logic [PC_W-1:0] PC;
  logic            imem_req;
  logic [8:0]      ir;
  logic            exec_en;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;
  int exp_pc = 0;

  fetch_seq #(.PC_W(PC_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .imem_ack (imem_ack),
    .instr    (instr),
    .do_a     (do_a),
    .lut_tgt  (lut_tgt),
    .PC       (PC),
    .imem_req (imem_req),
    .ir       (ir),
    .exec_en  (exec_en),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_next_pc(int pc, logic [8:0] w, logic [7:0] a, logic [7:0] tgt);
    int  op;
    bit  br;
    op = int'(w) / 64;
    br = (op == 4 && a == 8'd0) || (op == 5 && a != 8'd0);
    return br ? int'(tgt) : (pc + 1) % (1 << PC_W);
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    start    = 1'($urandom);
    imem_ack = 1'b1;
    instr    = 9'($urandom);
    tick();
    check_eq("rst_pc", 32'(PC), 32'd0);
    check_eq("rst_ir", 32'(ir), 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_exec", 32'(exec_en), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    reset    = 1'b0;
    start    = 1'b0;
    imem_ack = 1'b0;
    exp_pc   = 0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc = 0;
    check_eq("start_req", 32'(imem_req), 32'd1);
    check_eq("start_pc", 32'(PC), 32'd0);
  endtask

  // Entered with the DUT in its first FETCH cycle; leaves it in the next FETCH (or HALT).
  task automatic run_instr(input logic [8:0] w, input int delay, input logic [7:0] a,
                           input logic [7:0] tgt, output bit halted);
    halted = 1'b0;
    check_eq("fetch_req", 32'(imem_req), 32'd1);
    check_eq("fetch_pc", 32'(PC), 32'(exp_pc));
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      instr    = 9'($urandom);
      start    = 1'($urandom);
      tick();
      check_eq("wait_req", 32'(imem_req), 32'd1);
      check_eq("wait_err", 32'(err), 32'd0);
    end
    imem_ack = 1'b1;
    instr    = w;
    do_a     = a;
    lut_tgt  = tgt;
    start    = 1'($urandom);
    tick();
    check_eq("decode_ir", 32'(ir), 32'(w));
    check_eq("decode_req", 32'(imem_req), 32'd0);
    check_eq("decode_exec", 32'(exec_en), 32'd0);
    imem_ack = 1'($urandom);
    instr    = ~w;
    start    = 1'($urandom);
    tick();
    if (w == 9'h1FF) begin
      check_eq("halt_done", 32'(done), 32'd1);
      check_eq("halt_exec", 32'(exec_en), 32'd0);
      check_eq("halt_req", 32'(imem_req), 32'd0);
      check_eq("halt_pc", 32'(PC), 32'(exp_pc));
      halted   = 1'b1;
      imem_ack = 1'b0;
      start    = 1'b0;
      return;
    end
    check_eq("exec_en", 32'(exec_en), 32'd1);
    check_eq("exec_ir", 32'(ir), 32'(w));
    check_eq("exec_done", 32'(done), 32'd0);
    imem_ack = 1'($urandom);
    instr    = ~w;
    start    = 1'($urandom);
    tick();
    exp_pc = model_next_pc(exp_pc, w, a, tgt);
    check_eq("next_exec", 32'(exec_en), 32'd0);
    check_eq("next_req", 32'(imem_req), 32'd1);
    check_eq("next_pc", 32'(PC), 32'(exp_pc));
    check_eq("next_ir", 32'(ir), 32'(w));
    imem_ack = 1'b0;
    start    = 1'b0;
  endtask

  task automatic restart_from_halt();
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom);
      instr    = 9'($urandom);
      tick();
      check_eq("hold_done", 32'(done), 32'd1);
      check_eq("hold_pc", 32'(PC), 32'(exp_pc));
      check_eq("hold_ir", 32'(ir), 32'h1FF);
      check_eq("hold_exec", 32'(exec_en), 32'd0);
    end
    imem_ack = 1'b0;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    exp_pc = 0;
    check_eq("restart_done", 32'(done), 32'd0);
    check_eq("restart_pc", 32'(PC), 32'd0);
    check_eq("restart_req", 32'(imem_req), 32'd1);
  endtask

  function automatic logic [8:0] plain_word();
    logic [2:0] ops [6];
    logic [8:0] w;
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    w = {ops[$urandom_range(0, 5)], 6'($urandom)};
    if (w == 9'h1FF) w = 9'h1C0;
    return w;
  endfunction

  initial begin
    bit         h;
    logic [8:0] w;
    logic [7:0] a;
    int         r;

    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; instr = '0; do_a = '0; lut_tgt = '0;
    tick();
    tick();
    check_eq("init_pc", 32'(PC), 32'd0);
    check_eq("init_ir", 32'(ir), 32'd0);
    check_eq("init_req", 32'(imem_req), 32'd0);
    check_eq("init_flags", 32'({exec_en, done, err}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom);
      tick();
      check_eq("idle_req", 32'(imem_req), 32'd0);
      check_eq("idle_ir", 32'(ir), 32'd0);
    end
    imem_ack = 1'b0;

    start_run();
    run_instr(9'h001, 0, 8'h00, 8'h00, h);
    run_instr(9'h002, 0, 8'h00, 8'h00, h);
    check_eq("straight_pc", 32'(PC), 32'd2);
    run_instr(9'h100, 0, 8'h00, 8'h40, h);
    check_eq("bz_taken_pc", 32'(PC), 32'h40);
    run_instr(9'h140, 0, 8'h00, 8'h77, h);
    check_eq("bnz_fall_pc", 32'(PC), 32'h41);
    run_instr(9'h140, 0, 8'h05, 8'h10, h);
    check_eq("bnz_taken_pc", 32'(PC), 32'h10);
    run_instr(9'h003, MAX_WAIT - 1, 8'h00, 8'h00, h);
    check_eq("late_ack_err", 32'(err), 32'd0);
    run_instr(9'h1FF, 0, 8'h00, 8'h00, h);
    check_eq("halted_flag", 32'(h), 32'd1);
    restart_from_halt();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      w = {3'b100, 6'($urandom)};
      else if (r <= 6) w = {3'b101, 6'($urandom)};
      else if (r == 7) w = 9'h1FF;
      else             w = 9'($urandom);
      a = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
      run_instr(w, $urandom_range(0, MAX_WAIT - 1), a, 8'($urandom), h);
      if (h) restart_from_halt();
    end

    do_reset();
    start_run();
    for (int n = 0; n < (1 << PC_W); n++) begin
      run_instr(plain_word(), 0, 8'($urandom), 8'($urandom), h);
    end
    check_eq("wrap_pc", 32'(PC), 32'd0);

    do_reset();
    start_run();
    imem_ack = 1'b0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      start = 1'($urandom);
      tick();
      if (i < MAX_WAIT) begin
        check_eq("to_wait_err", 32'(err), 32'd0);
        check_eq("to_wait_req", 32'(imem_req), 32'd1);
      end else begin
        check_eq("to_err", 32'(err), 32'd1);
        check_eq("to_req", 32'(imem_req), 32'd0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      instr    = 9'($urandom);
      start    = 1'b1;
      tick();
      check_eq("fault_err", 32'(err), 32'd1);
      check_eq("fault_req", 32'(imem_req), 32'd0);
      check_eq("fault_pc", 32'(PC), 32'd0);
      check_eq("fault_ir", 32'(ir), 32'd0);
      check_eq("fault_strobes", 32'({exec_en, done}), 32'd0);
    end
    do_reset();
    tick();
    check_eq("post_fault_idle", 32'(imem_req), 32'd0);

    start_run();
    run_instr(9'h005, 0, 8'h00, 8'h00, h);
    imem_ack = 1'b1; instr = 9'h100; do_a = 8'h00; lut_tgt = 8'h40;
    tick();
    imem_ack = 1'b0;
    tick();
    check_eq("mid_exec_en", 32'(exec_en), 32'd1);
    reset = 1'b1; start = 1'b1;
    tick();
    check_eq("mid_rst_pc", 32'(PC), 32'd0);
    check_eq("mid_rst_exec", 32'(exec_en), 32'd0);
    check_eq("mid_rst_req", 32'(imem_req), 32'd0);
    check_eq("mid_rst_ir", 32'(ir), 32'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    check_eq("mid_rst_after", 32'({exec_en, imem_req, done, err}), 32'd0);

    start_run();
    imem_ack = 1'b1; instr = 9'h010;
    tick();
    imem_ack = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("exec_start_pc", 32'(PC), 32'd1);
    check_eq("exec_start_req", 32'(imem_req), 32'd1);

    imem_ack = 1'b1; instr = 9'h0AA; reset = 1'b1;
    tick();
    reset = 1'b0; imem_ack = 1'b0;
    check_eq("fetch_rst_ir", 32'(ir), 32'd0);
    check_eq("fetch_rst_req", 32'(imem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
